// File: rtl/parking_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parking_ctrl_if : sensor/passcode inputs and gate/display outputs of
//                   the parking-entry controller.
// Revision 1.0
// ---------------------------------------------------------------------------
interface parking_ctrl_if #(
  parameter int PSD_W    = 32,
  parameter int CAPACITY = 8
);
  localparam int CNT_W = $clog2(CAPACITY + 1);

  logic             car;
  logic             f_sen;
  logic             b_sen;
  logic [PSD_W-1:0] psd;
  logic             psd_valid;
  logic             exit_sen;
  logic             gate;
  logic             e;
  logic             full;
  logic             alarm;
  logic [CNT_W-1:0] count;

  modport master (
    output car, f_sen, b_sen, psd, psd_valid, exit_sen,
    input  gate, e, full, alarm, count
  );

  modport slave (
    input  car, f_sen, b_sen, psd, psd_valid, exit_sen,
    output gate, e, full, alarm, count
  );
endinterface
`default_nettype wire

// File: rtl/parking_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parking_ctrl : occupancy tracking, passcode check, retry lockout and gate
//                timeout for a parking-lot entry lane. All outputs registered.
// Revision 1.0
// ---------------------------------------------------------------------------
module parking_ctrl #(
  parameter int               PSD_W        = 32,
  parameter logic [PSD_W-1:0] PASSWORD     = PSD_W'(1359),
  parameter int               CAPACITY     = 8,
  parameter int               MAX_TRIES    = 3,
  parameter int               GATE_TIMEOUT = 16,
  parameter int               LOCK_CYCLES  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  parking_ctrl_if.slave bus
);

  localparam int CNT_W   = $clog2(CAPACITY + 1);
  localparam int RTY_W   = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = ((GATE_TIMEOUT > LOCK_CYCLES) ? GATE_TIMEOUT : LOCK_CYCLES) - 1;
  localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);
  localparam logic [RTY_W-1:0] TRIES_C   = RTY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(GATE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_OPEN  = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  state_t           state_q;
  logic             gate_q;
  logic             e_q;
  logic             alarm_q;
  logic             full_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [RTY_W-1:0] retry_q;
  logic [RTY_W-1:0] retry_inc;
  logic [TMR_W-1:0] timer_q;
  logic             entry_ok;
  logic             exit_ok;

  // A simultaneous entry and exit cancel out; exits at zero are dropped.
  always_comb begin
    entry_ok  = (state_q == S_OPEN) && bus.b_sen;
    exit_ok   = bus.exit_sen && (count_q != '0);
    retry_inc = retry_q + 1'b1;
    count_d   = count_q;
    if (entry_ok && !exit_ok) begin
      count_d = count_q + 1'b1;
    end else if (!entry_ok && exit_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gate_q  <= 1'b0;
      e_q     <= 1'b0;
      alarm_q <= 1'b0;
      full_q  <= 1'b0;
      count_q <= '0;
      retry_q <= '0;
      timer_q <= '0;
    end else begin
      e_q     <= 1'b0;
      count_q <= count_d;
      full_q  <= (count_d == CAP_C);
      case (state_q)
        S_IDLE: begin
          gate_q  <= 1'b0;
          alarm_q <= 1'b0;
          if (bus.car && bus.f_sen && !full_q) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!bus.car) begin
            state_q <= S_IDLE;
            retry_q <= '0;
          end else if (bus.psd_valid) begin
            if (bus.psd == PASSWORD) begin
              state_q <= S_OPEN;
              gate_q  <= 1'b1;
              retry_q <= '0;
              timer_q <= GATE_LOAD;
            end else begin
              retry_q <= retry_inc;
              if (retry_inc == TRIES_C) begin
                state_q <= S_LOCK;
                alarm_q <= 1'b1;
                timer_q <= LOCK_LOAD;
              end
            end
          end
        end
        S_OPEN: begin
          // The car clearing the rear sensor beats a simultaneous timeout.
          if (bus.b_sen) begin
            state_q <= S_IDLE;
            gate_q  <= 1'b0;
            e_q     <= 1'b1;
          end else if (timer_q == '0) begin
            state_q <= S_IDLE;
            gate_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_LOCK: begin
          gate_q <= 1'b0;
          if (timer_q == '0) begin
            state_q <= S_IDLE;
            alarm_q <= 1'b0;
            retry_q <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gate  = gate_q;
  assign bus.e     = e_q;
  assign bus.full  = full_q;
  assign bus.alarm = alarm_q;
  assign bus.count = count_q;

endmodule
`default_nettype wire

// File: doc/parking_ctrl.md
# parking_ctrl

Parametrised parking-entry controller, successor to the single-car gate block. It does four things:
- tracks lot occupancy against a configurable capacity;
- validates a strobed entry passcode;
- limits wrong-passcode retries with a timed lockout and alarm;
- closes the gate automatically if the car never clears the rear sensor.

It sits between the entry/exit sensor front-end and the gate actuator and display logic. All outputs are registered.

## Interface
Parameters:
- PSD_W, 32, passcode width
- PASSWORD, 1359, accepted passcode (PSD_W bits)
- CAPACITY, 8, number of slots (≥1)
- MAX_TRIES, 3, wrong passcodes allowed before lockout (≥1)
- GATE_TIMEOUT, 16, maximum cycles the gate stays open waiting for b_sen (≥1)
- LOCK_CYCLES, 32, lockout duration in cycles (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- car  in  1  car present at entry lane
- f_sen  in  1  front sensor
- b_sen  in  1  back sensor (car has passed the gate)
- psd  in  PSD_W  passcode value
- psd_valid  in  1  one-cycle strobe; psd is sampled only when this is high
- exit_sen  in  1  one-cycle pulse per car leaving the lot
- gate  out  1  gate open
- e  out  1  one-cycle entry-accepted pulse
- full  out  1  count == CAPACITY
- alarm  out  1  lockout active
- count  out  $clog2(CAPACITY+1)  occupied slots

## Operation
- One clock and one reset.
- Reset is synchronous and active-low. While rst_n=0 at a rising edge:
  - state=IDLE;
  - gate=0, e=0, alarm=0, count=0, full=0;
  - retry counter=0, timer=0.
- Reset overrides everything, mid-operation included; the gate closes on the reset edge.

State machine (registered, 2-bit):
- IDLE: gate=0.
  - car && f_sen && !full → CHECK.
  - If full, stay in IDLE; the request is ignored.
- CHECK: gate=0, waiting for the passcode.
  - car==0 → IDLE and clear the retry counter. This takes priority over psd_valid.
  - psd_valid && psd==PASSWORD → OPEN, gate=1, clear the retry counter, timer=GATE_TIMEOUT-1.
  - psd_valid && psd!=PASSWORD → increment the retry counter.
    - If the new value == MAX_TRIES → LOCK, alarm=1, timer=LOCK_CYCLES-1.
    - Otherwise stay in CHECK.
- OPEN: gate=1.
  - b_sen → IDLE, gate=0, e=1 for one cycle, count+1.
  - Otherwise, if timer==0 → IDLE, gate=0, count unchanged, no e pulse.
  - Otherwise decrement the timer.
  - b_sen wins over expiry in the same cycle.
- LOCK: alarm=1, gate=0; car, f_sen, b_sen and psd are all ignored.
  - timer==0 → IDLE, alarm=0, clear the retry counter.
  - Otherwise decrement the timer.

Occupancy:
- exit_sen decrements count when count>0. At count 0 it is ignored; no underflow.
- Entry increment and exit decrement in the same cycle → count unchanged.
- exit_sen is honoured in every state.
- count never exceeds CAPACITY, because entry is only granted when not full.
- full is registered and always equals (count==CAPACITY) after each edge.

Widths:
- Retry counter: $clog2(MAX_TRIES+1) bits.
- Timer: sized for max(GATE_TIMEOUT, LOCK_CYCLES)-1.
- Passcode compare is a full PSD_W-bit equality.

## Timing
- car && f_sen sampled at edge N → CHECK after edge N. The earliest accepted psd_valid is at edge N+1.
- Correct passcode sampled at edge M → gate=1 after edge M (1-cycle latency).
- gate stays high for at most GATE_TIMEOUT cycles without b_sen.
- b_sen sampled at edge K → gate=0, e=1 and the new count after edge K. e drops after edge K+1.
- alarm stays high for exactly LOCK_CYCLES cycles. The next entry request is accepted at the first edge in IDLE.
- exit_sen sampled at edge X → count and full update after edge X.

## Test plan
1. Reset, then car=1, f_sen=1. Next cycle psd=1359 with psd_valid. Then after 3 cycles b_sen=1.
   → gate=1 one cycle after the strobe; e pulses once; count=1; gate=0.
2. Three wrong passcodes (e.g. 1234) in CHECK.
   → alarm=1 after the third; gate stays 0 and psd=1359 is ignored for 32 cycles.
   → After that: alarm=0 and IDLE; a correct code on a new request opens the gate.
3. Correct passcode with b_sen held low.
   → gate high exactly 16 cycles, then 0; no e pulse; count unchanged.
4. Fill to count=8.
   → full=1; a new car/f_sen request stays in IDLE, gate=0.
   → One exit_sen pulse → count=7, full=0; the next request is accepted.
5. count=3, b_sen in OPEN coincides with exit_sen → count stays 3 and e pulses.
   With count=0, exit_sen → count stays 0.
6. rst_n low in OPEN with count=5 → next edge: gate=0, count=0, alarm=0, state IDLE.
   Also: car dropped in CHECK after one wrong code → IDLE; retries are cleared, so 3 further wrong codes are needed to lock.
